// File: rtl/fn1_div_pkg.sv
// Shared constants, FSM encoding and helpers for the sequential signed divider.
// Everything width-related is derived from W so the datapath stays consistent.
package fn1_div_pkg;

  localparam int W     = 14;
  localparam int ITERS = 14;
  localparam int CW    = $clog2(ITERS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } div_res_t;

  // One bit wider than the operand so the most negative value keeps its
  // magnitude (-8192 -> 8192) instead of wrapping back to itself.
  function automatic logic [W:0] mag(input logic [W-1:0] x);
    logic [W:0] sx;
    sx = {x[W-1], x};
    return x[W-1] ? (~sx + 1'b1) : sx;
  endfunction

endpackage

// File: rtl/fn1_udiv_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, subtract the divisor when it fits, emit one quotient bit.
module fn1_udiv_step
  import fn1_div_pkg::*;
(
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] q_in,
  input  logic [W:0]   d,
  output logic [W-1:0] r_out,
  output logic [W-1:0] q_out
);

  logic [W:0] r_sh;
  logic       ge;

  // q_in doubles as the dividend shift register: its MSB feeds the remainder
  // while the new quotient bit enters at the LSB.
  always_comb begin
    r_sh  = {r_in, q_in[W-1]};
    ge    = (r_sh >= d);
    r_out = ge ? W'(r_sh - d) : W'(r_sh);
    q_out = {q_in[W-2:0], ge};
  end

endmodule

// File: rtl/fn1_sdiv_seq_14s_14s_14.sv
// Sequential signed divider: 14 restoring steps on magnitudes, a sign fix-up
// cycle, then a one-cycle done pulse with quotient, remainder and dbz flag.
module fn1_sdiv_seq_14s_14s_14
  import fn1_div_pkg::*;
#(
  parameter ID         = 32'd1,
  parameter din0_WIDTH = 32'd14,
  parameter din1_WIDTH = 32'd14,
  parameter dout_WIDTH = 32'd14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  dbz
);

  logic         unused_id;
  assign unused_id = ^ID;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          s0, s1, dbz_p;
  logic [W-1:0]  n0;
  logic [W-1:0]  quo, par;
  logic [W:0]    dv;
  logic [W-1:0]  q_nx, r_nx;
  div_res_t      res;

  fn1_udiv_step u_step (
    .r_in  (par),
    .q_in  (quo),
    .d     (dv),
    .r_out (r_nx),
    .q_out (q_nx)
  );

  // The done cycle is spent back in IDLE, so a held start is taken on the
  // edge that ends it; busy covers that cycle explicitly.
  assign busy = (state != S_IDLE) | done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      dbz_p <= 1'b0;
      n0    <= '0;
      quo   <= '0;
      par   <= '0;
      dv    <= '0;
      res   <= '0;
      done  <= 1'b0;
      dout  <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n0    <= din0;
            s0    <= din0[W-1];
            s1    <= din1[W-1];
            quo   <= W'(mag(din0));
            dv    <= mag(din1);
            par   <= '0;
            cnt   <= '0;
            dbz_p <= (din1 == '0);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          quo <= q_nx;
          par <= r_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) state <= S_FIX;
        end
        S_FIX: begin
          // Truncating division: quotient sign is the XOR of operand signs,
          // remainder follows the dividend. Divide-by-zero is pinned explicitly.
          res.q   <= dbz_p ? '1 : ((s0 ^ s1) ? -quo : quo);
          res.r   <= dbz_p ? n0 : (s0 ? -par : par);
          res.dbz <= dbz_p;
          state   <= S_DONE;
        end
        S_DONE: begin
          dout  <= res.q;
          rem   <= res.r;
          dbz   <= res.dbz;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fn1_sdiv_seq_14s_14s_14.sv
// Directed bench for the sequential signed divider: latency, signs, boundaries,
// clock-enable stalls, mid-operation reset and back-to-back issue.
module tb_fn1_sdiv_seq_14s_14s_14;

  logic        clk = 1'b0;
  logic        reset, ce, start;
  logic [13:0] din0, din1;
  logic        busy, done, dbz;
  logic [13:0] dout, rem;

  int checks = 0;
  int errors = 0;

  fn1_sdiv_seq_14s_14s_14 dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count ce-enabled/any edges until done (bounded).
  task automatic run_op(input int a, input int b, output int lat);
    din0  = 14'(a);
    din1  = 14'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    ce = 1'b0; start = 1'b0; din0 = '0; din1 = '0;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, dbz} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/done/dbz=%b expected 000", {busy, done, dbz});
    end
    checks++;
    if (dout !== 14'd0 || rem !== 14'd0) begin
      errors++; $display("FAIL reset_data: got dout=%h rem=%h expected 0 0", dout, rem);
    end
    reset = 1'b0; ce = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic;
    int lat;
    run_op(100, 7, lat);
    checks++;
    if (lat !== 16) begin
      errors++; $display("FAIL basic_lat: got %0d expected 16", lat);
    end
    checks++;
    if ($signed(dout) !== 14 || $signed(rem) !== 2 || dbz !== 1'b0) begin
      errors++; $display("FAIL basic_val: got q=%0d r=%0d dbz=%b expected 14 2 0", $signed(dout), $signed(rem), dbz);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_done: got busy=%b expected 1", busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
    checks++;
    if ($signed(dout) !== 14 || $signed(rem) !== 2) begin
      errors++; $display("FAIL basic_hold: got q=%0d r=%0d expected 14 2", $signed(dout), $signed(rem));
    end
  endtask

  task automatic test_signs;
    int ta[8] = '{-100,  100, -100,  100,  -5, -8192, -8192, 8191};
    int tb[8] = '{   7,   -7,   -7,    0,   0,    -1,     3,    1};
    int tq[8] = '{ -14,  -14,   14,   -1,  -1, -8192, -2730, 8191};
    int tr[8] = '{  -2,    2,   -2,  100,  -5,     0,    -2,    0};
    int tz[8] = '{   0,    0,    0,    1,   1,     0,     0,    0};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], lat);
      checks++;
      if (lat !== 16) begin
        errors++; $display("FAIL signs_lat[%0d]: got %0d expected 16", i, lat);
      end
      checks++;
      if ($signed(dout) !== tq[i] || $signed(rem) !== tr[i] || int'(dbz) !== tz[i]) begin
        errors++;
        $display("FAIL signs_val[%0d] %0d/%0d: got q=%0d r=%0d dbz=%b expected %0d %0d %0d",
                 i, ta[i], tb[i], $signed(dout), $signed(rem), dbz, tq[i], tr[i], tz[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall;
    int n;
    din0 = 14'd25; din1 = 14'd5; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    repeat (3) begin tick(); n++; end
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); n++;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || $signed(dout) !== 8191 || rem !== 14'd0) begin
        errors++;
        $display("FAIL stall_frozen[%0d]: got done=%b busy=%b q=%0d r=%0d expected 0 1 8191 0",
                 i, done, busy, $signed(dout), $signed(rem));
      end
    end
    ce = 1'b1;
    while (!done && n < 60) begin tick(); n++; end
    checks++;
    if (n !== 21) begin
      errors++; $display("FAIL stall_lat: got %0d expected 21", n);
    end
    checks++;
    if ($signed(dout) !== 5 || $signed(rem) !== 0) begin
      errors++; $display("FAIL stall_val: got q=%0d r=%0d expected 5 0", $signed(dout), $signed(rem));
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int seen, lat;
    din0 = 14'd100; din1 = 14'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (20) begin tick(); if (done) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rstmid_nodone: got %0d pulses expected 0", seen);
    end
    checks++;
    if (busy !== 1'b0 || dbz !== 1'b0 || dout !== 14'd0 || rem !== 14'd0) begin
      errors++; $display("FAIL rstmid_clear: got busy=%b dbz=%b q=%h r=%h expected 0 0 0 0", busy, dbz, dout, rem);
    end
    run_op(9, 2, lat);
    checks++;
    if (lat !== 16 || $signed(dout) !== 4 || $signed(rem) !== 1) begin
      errors++; $display("FAIL rstmid_next: got lat=%0d q=%0d r=%0d expected 16 4 1", lat, $signed(dout), $signed(rem));
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int k, idle, n;
    int at[4];
    din0 = 14'd50; din1 = 14'd3; start = 1'b1;
    tick();
    k = 0; idle = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!busy) idle++;
      if (done) begin
        if (k < 4) at[k] = i;
        k++;
        checks++;
        if ($signed(dout) !== 16 || $signed(rem) !== 2) begin
          errors++; $display("FAIL b2b_val: got q=%0d r=%0d expected 16 2", $signed(dout), $signed(rem));
        end
      end
    end
    checks++;
    if (k !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d pulses expected 2", k);
    end else begin
      checks++;
      if (at[0] !== 16 || at[1] !== 33) begin
        errors++; $display("FAIL b2b_timing: got %0d,%0d expected 16,33", at[0], at[1]);
      end
    end
    checks++;
    if (idle !== 0) begin
      errors++; $display("FAIL b2b_busy: got %0d idle cycles expected 0", idle);
    end
    start = 1'b0;
    n = 0;
    while (!done && n < 30) begin tick(); n++; end
    checks++;
    if (n !== 10) begin
      errors++; $display("FAIL b2b_third: got done after %0d expected 10", n);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
